// File: rtl/uart_transmitter_if.sv
// Handshake and serial-line bundle between a byte source and uart_transmitter.
// The source side uses the master modport; the transmitter uses slave.
interface uart_transmitter_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_data;

    modport master (
        output tx_start, tx_byte,
        input  tx_ready, tx_busy, tx_done, tx_data
    );

    modport slave (
        input  tx_start, tx_byte,
        output tx_ready, tx_busy, tx_done, tx_data
    );
endinterface

// File: rtl/uart_transmitter.sv
// Serialises one byte: idle LOW, start HIGH, 8 data bits LSB first, stop LOW, BIT_CYCLES clocks per bit.
// Optional macro TX_HOLD_EN adds a one-byte holding register so the next byte can queue during a frame.
module uart_transmitter #(
    parameter int BIT_CYCLES = 10_000_001,
    parameter int CNT_W      = 32
) (
    input logic             clk,
    input logic             rst,
    uart_transmitter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BIT_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             busy;
    logic             done;
    logic             data;
    logic             ready;
    logic             accept;
    logic             bit_end;

`ifdef TX_HOLD_EN
    logic [7:0] hold;
    logic       hold_valid;
    logic       drain;

    assign ready = !hold_valid;
    assign drain = hold_valid && ((state == STOP && bit_end) || state == IDLE);
`else
    assign ready = !busy;
`endif

    assign accept  = bus.tx_start && ready;
    assign bit_end = (cnt == CNT_LAST);

    assign bus.tx_ready = ready;
    assign bus.tx_busy  = busy;
    assign bus.tx_done  = done;
    assign bus.tx_data  = data;

    // The line value for the coming clock is loaded together with each state change,
    // so tx_data is a plain register and bit boundaries never drift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            data    <= 1'b0;
`ifdef TX_HOLD_EN
            hold       <= '0;
            hold_valid <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    data <= 1'b0;
                    cnt  <= '0;
                    if (accept) begin
                        shift <= bus.tx_byte;
                        state <= START;
                        busy  <= 1'b1;
                        data  <= 1'b1;
                    end
`ifdef TX_HOLD_EN
                    else if (hold_valid) begin
                        shift <= hold;
                        state <= START;
                        busy  <= 1'b1;
                        data  <= 1'b1;
                    end
`endif
                end
                START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        data    <= shift[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            data  <= 1'b0;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            data    <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
`ifdef TX_HOLD_EN
                        if (hold_valid) begin
                            shift <= hold;
                            state <= START;
                            data  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_PRE) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef TX_HOLD_EN
            // A new byte arriving on the drain edge wins, so hold_valid stays set.
            if (accept && busy) begin
                hold       <= bus.tx_byte;
                hold_valid <= 1'b1;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at BIT_CYCLES=4 with a behavioural copy of the LED receiver.
// Define TX_HOLD_EN for both bench and RTL to exercise the holding-register build.
module tb_uart_transmitter;

    localparam int BC = 4;
`ifdef TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    uart_transmitter_if bus ();

    uart_transmitter #(.BIT_CYCLES(BC), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Receiver model: waits for the HIGH start bit, samples each data bit mid-period.
    logic       rx_act = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_leds = 8'h00;
    int         rx_frames = 0;

    always @(posedge clk) begin
        if (rst) begin
            rx_act <= 1'b0;
        end else if (!rx_act) begin
            if (bus.tx_data === 1'b1) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
                rx_sh <= {bus.tx_data, rx_sh[7:1]};
            if (rx_cnt == 38) begin
                rx_leds   <= rx_sh;
                rx_frames <= rx_frames + 1;
                rx_act    <= 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++;
        if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got data=%b busy=%b ready=%b done=%b want 0 0 1 0",
                     bus.tx_data, bus.tx_busy, bus.tx_ready, bus.tx_done);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL idle_%0d: got data=%b busy=%b ready=%b done=%b want 0 0 1 0",
                         k, bus.tx_data, bus.tx_busy, bus.tx_ready, bus.tx_done);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] f;
        f = {1'b0, 8'hA5, 1'b1};
        bus.tx_byte  = 8'hA5;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        bus.tx_byte  = 8'h5A;
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (bus.tx_data !== f[(k-1)/BC] || bus.tx_busy !== 1'b1 || bus.tx_done !== (k == 40)
                || bus.tx_ready !== HOLD) begin
                bad++;
                $display("[TB] FAIL single_clk%0d: got data=%b busy=%b done=%b ready=%b want %b 1 %b %b",
                         k, bus.tx_data, bus.tx_busy, bus.tx_done, bus.tx_ready, f[(k-1)/BC], (k == 40), HOLD);
            end
            step();
        end
        total++;
        if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_end: got data=%b busy=%b ready=%b done=%b want 0 0 1 0",
                     bus.tx_data, bus.tx_busy, bus.tx_ready, bus.tx_done);
        end
        total++;
        if (rx_leds !== 8'hA5) begin
            bad++;
            $display("[TB] FAIL single_rx: got %h want a5", rx_leds);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] f0;
        logic [9:0] f1;
        f0 = {1'b0, 8'h00, 1'b1};
        f1 = {1'b0, 8'hFF, 1'b1};
        bus.tx_byte  = 8'h00;
        bus.tx_start = 1'b1;
        step();
        bus.tx_byte = 8'hFF;
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (bus.tx_data !== f0[(k-1)/BC] || bus.tx_busy !== 1'b1 || bus.tx_done !== (k == 40)) begin
                bad++;
                $display("[TB] FAIL b2b_first_clk%0d: got data=%b busy=%b done=%b want %b 1 %b",
                         k, bus.tx_data, bus.tx_busy, bus.tx_done, f0[(k-1)/BC], (k == 40));
            end
`ifdef TX_HOLD_EN
            if (k == 2) bus.tx_start = 1'b0;
`endif
            step();
        end
        total++;
        if (rx_leds !== 8'h00) begin
            bad++;
            $display("[TB] FAIL b2b_rx_first: got %h want 00", rx_leds);
        end
`ifndef TX_HOLD_EN
        total++;
        if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_gap: got data=%b busy=%b ready=%b want 0 0 1",
                     bus.tx_data, bus.tx_busy, bus.tx_ready);
        end
        step();
        bus.tx_start = 1'b0;
`endif
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (bus.tx_data !== f1[(k-1)/BC] || bus.tx_busy !== 1'b1 || bus.tx_done !== (k == 40)) begin
                bad++;
                $display("[TB] FAIL b2b_second_clk%0d: got data=%b busy=%b done=%b want %b 1 %b",
                         k, bus.tx_data, bus.tx_busy, bus.tx_done, f1[(k-1)/BC], (k == 40));
            end
            step();
        end
        total++;
        if (rx_leds !== 8'hFF || bus.tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_end: got rx=%h busy=%b want ff 0", rx_leds, bus.tx_busy);
        end
    endtask

`ifndef TX_HOLD_EN
    task automatic test_ignore();
        logic [9:0] f;
        int         frames_before;
        f = {1'b0, 8'h96, 1'b1};
        frames_before = rx_frames;
        bus.tx_byte  = 8'h96;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (bus.tx_data !== f[(k-1)/BC] || bus.tx_ready !== 1'b0 || bus.tx_busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL ignore_clk%0d: got data=%b ready=%b busy=%b want %b 0 1",
                         k, bus.tx_data, bus.tx_ready, bus.tx_busy, f[(k-1)/BC]);
            end
            if (k == 15) begin
                bus.tx_start = 1'b1;
                bus.tx_byte  = 8'h11;
            end
            if (k == 16) bus.tx_start = 1'b0;
            step();
        end
        for (int k = 0; k < 45; k++) begin
            total++;
            if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ignore_after_%0d: got data=%b busy=%b want 0 0", k, bus.tx_data, bus.tx_busy);
            end
            step();
        end
        total++;
        if (rx_leds !== 8'h96 || rx_frames !== frames_before + 1) begin
            bad++;
            $display("[TB] FAIL ignore_rx: got leds=%h frames=%0d want 96 %0d", rx_leds, rx_frames, frames_before + 1);
        end
    endtask
`endif

`ifdef TX_HOLD_EN
    task automatic test_hold();
        logic [9:0] f1;
        logic [9:0] f2;
        logic       exp_d;
        f1 = {1'b0, 8'h3C, 1'b1};
        f2 = {1'b0, 8'hC3, 1'b1};
        bus.tx_byte  = 8'h3C;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            exp_d = (k <= 40) ? f1[(k-1)/BC] : f2[(k-41)/BC];
            total++;
            if (bus.tx_data !== exp_d || bus.tx_busy !== 1'b1 || bus.tx_done !== (k == 40 || k == 80)
                || bus.tx_ready !== (k <= 10 || k >= 41)) begin
                bad++;
                $display("[TB] FAIL hold_clk%0d: got data=%b busy=%b done=%b ready=%b want %b 1 %b %b",
                         k, bus.tx_data, bus.tx_busy, bus.tx_done, bus.tx_ready,
                         exp_d, (k == 40 || k == 80), (k <= 10 || k >= 41));
            end
            if (k == 10) begin
                bus.tx_start = 1'b1;
                bus.tx_byte  = 8'hC3;
            end
            if (k == 11) begin
                bus.tx_start = 1'b0;
                bus.tx_byte  = 8'h00;
            end
            step();
        end
        total++;
        if (rx_leds !== 8'hC3 || bus.tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_end: got rx=%h busy=%b want c3 0", rx_leds, bus.tx_busy);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [9:0] f0;
        logic [9:0] f;
        f0 = {1'b0, 8'hA5, 1'b1};
        f  = {1'b0, 8'h5A, 1'b1};
        bus.tx_byte  = 8'hA5;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            total++;
            if (bus.tx_data !== f0[(k-1)/BC]) begin
                bad++;
                $display("[TB] FAIL rstmid_clk%0d: got data=%b want %b", k, bus.tx_data, f0[(k-1)/BC]);
            end
            if (k == 17) rst = 1'b1;
            step();
        end
        rst = 1'b0;
        total++;
        if (bus.tx_data !== 1'b0 || bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_abort: got data=%b busy=%b ready=%b done=%b want 0 0 1 0",
                     bus.tx_data, bus.tx_busy, bus.tx_ready, bus.tx_done);
        end
        step();
        step();
        bus.tx_byte  = 8'h5A;
        bus.tx_start = 1'b1;
        step();
        bus.tx_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            total++;
            if (bus.tx_data !== f[(k-1)/BC] || bus.tx_busy !== 1'b1 || bus.tx_done !== (k == 40)) begin
                bad++;
                $display("[TB] FAIL rstmid_frame_clk%0d: got data=%b busy=%b done=%b want %b 1 %b",
                         k, bus.tx_data, bus.tx_busy, bus.tx_done, f[(k-1)/BC], (k == 40));
            end
            step();
        end
        total++;
        if (rx_leds !== 8'h5A || bus.tx_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_rx: got rx=%h busy=%b want 5a 0", rx_leds, bus.tx_busy);
        end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_byte  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
`ifdef TX_HOLD_EN
        test_hold();
`else
        test_ignore();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
